// File: rtl/op_stack_pkg.sv
// Shared stack command interface: command width and command codes.
package op_stack_pkg;

    localparam int unsigned SC_N = 3;

    typedef enum logic [SC_N-1:0] {
        SC_NOP = 3'd0,
        SC_PUS = 3'd1,
        SC_POP = 3'd2,
        SC_TOP = 3'd3,
        SC_DUP = 3'd4,
        SC_SWP = 3'd5,
        SC_CLR = 3'd6
    } sc_e;

endpackage

// File: rtl/op_stack_ram.sv
// Stack storage: N x 2**AW array, two async read ports and two write ports,
// kept separate so a memory macro can be dropped in later.
module stack_ram #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          wr0_en,
    input  logic [AW-1:0] wr0_addr,
    input  logic [N-1:0]  wr0_data,
    input  logic          wr1_en,
    input  logic [AW-1:0] wr1_addr,
    input  logic [N-1:0]  wr1_data,
    input  logic [AW-1:0] rd0_addr,
    input  logic [AW-1:0] rd1_addr,
    output logic [N-1:0]  rd0_data_c,
    output logic [N-1:0]  rd1_data_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [N-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
    end

    assign rd0_data_c = mem[rd0_addr];
    assign rd1_data_c = mem[rd1_addr];

endmodule

// File: rtl/op_stack.sv
// Operand stack with shared tri-state data bus: command decode, pointer and
// sticky error flag; results are driven one cycle after POP/TOP.
module op_stack
    import op_stack_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    inout  wire  [N-1:0]    data,
    input  logic [SC_N-1:0] cmd,
    output logic [AW:0]     count,
    output logic            empty,
    output logic            full,
    output logic            err
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [N-1:0]     buff, buff_nxt;
    logic             out_ena, out_ena_nxt;
    logic             err_nxt;

    logic [AW-1:0]    top_addr, sec_addr;
    logic [N-1:0]     top_data, sec_data;
    logic             wr0_en, wr1_en;
    logic [AW-1:0]    wr0_addr, wr1_addr;
    logic [N-1:0]     wr0_data, wr1_data;
    logic             is_empty, is_full, has_two;

    assign top_addr = AW'(ptr - PTR_W'(1));
    assign sec_addr = AW'(ptr - PTR_W'(2));
    assign is_empty = (ptr == '0);
    assign is_full  = (ptr == PTR_W'(DEPTH));
    assign has_two  = (ptr >= PTR_W'(2));

    stack_ram #(.N(N), .AW(AW)) u_ram (
        .clk        (clk),
        .wr0_en     (wr0_en),
        .wr0_addr   (wr0_addr),
        .wr0_data   (wr0_data),
        .wr1_en     (wr1_en),
        .wr1_addr   (wr1_addr),
        .wr1_data   (wr1_data),
        .rd0_addr   (top_addr),
        .rd1_addr   (sec_addr),
        .rd0_data_c (top_data),
        .rd1_data_c (sec_data)
    );

    // Next-state decode; failing commands only raise err and release the bus.
    always_comb begin
        ptr_nxt     = ptr;
        buff_nxt    = buff;
        err_nxt     = err;
        out_ena_nxt = 1'b0;
        wr0_en      = 1'b0;
        wr0_addr    = AW'(ptr);
        wr0_data    = data;
        wr1_en      = 1'b0;
        wr1_addr    = sec_addr;
        wr1_data    = top_data;
        case (cmd)
            SC_PUS: begin
                if (is_full) err_nxt = 1'b1;
                else begin
                    wr0_en  = 1'b1;
                    ptr_nxt = ptr + PTR_W'(1);
                end
            end
            SC_POP: begin
                if (is_empty) err_nxt = 1'b1;
                else begin
                    buff_nxt    = top_data;
                    ptr_nxt     = ptr - PTR_W'(1);
                    out_ena_nxt = 1'b1;
                end
            end
            SC_TOP: begin
                if (is_empty) err_nxt = 1'b1;
                else begin
                    buff_nxt    = top_data;
                    out_ena_nxt = 1'b1;
                end
            end
            SC_DUP: begin
                if (is_empty || is_full) err_nxt = 1'b1;
                else begin
                    wr0_en   = 1'b1;
                    wr0_data = top_data;
                    ptr_nxt  = ptr + PTR_W'(1);
                end
            end
            SC_SWP: begin
                if (!has_two) err_nxt = 1'b1;
                else begin
                    wr0_en   = 1'b1;
                    wr0_addr = top_addr;
                    wr0_data = sec_data;
                    wr1_en   = 1'b1;
                end
            end
            SC_CLR: begin
                ptr_nxt = '0;
                err_nxt = 1'b0;
            end
            default: ;
        endcase
        // No command executes while reset is held, including RAM writes.
        wr0_en = wr0_en & rst_n;
        wr1_en = wr1_en & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            buff    <= '0;
            out_ena <= 1'b0;
            err     <= 1'b0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            buff    <= buff_nxt;
            out_ena <= out_ena_nxt;
            err     <= err_nxt;
            empty   <= (ptr_nxt == '0);
            full    <= (ptr_nxt == PTR_W'(DEPTH));
        end
    end

    assign count = ptr;
    assign data  = out_ena ? buff : {N{1'bz}};

endmodule

// File: tb/tb_op_stack.sv
// Bench for op_stack: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_op_stack;
    import op_stack_pkg::*;

    localparam int unsigned N     = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SC_N-1:0] cmd = SC_NOP;
    logic [N-1:0]    drv = '0;
    logic            tb_en;
    wire  [N-1:0]    data;
    logic [AW:0]     count;
    logic            empty, full, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    op_stack #(.N(N), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .cmd   (cmd),
        .count (count),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    // Reference model: a queue whose back is the top of stack.
    logic [N-1:0] m_stk[$];
    logic         m_err   = 1'b0;
    logic         m_drive = 1'b0;
    logic [N-1:0] m_val   = '0;

    // The bench drives its probe value whenever the model says the DUT must
    // release the bus, so a DUT that keeps driving corrupts the probe.
    assign tb_en = !m_drive;
    assign data  = tb_en ? drv : {N{1'bz}};

    always @(posedge clk or negedge rst_n) begin : model
        int sz;
        logic [N-1:0] tmp;
        if (!rst_n) begin
            m_stk.delete();
            m_err   <= 1'b0;
            m_drive <= 1'b0;
            m_val   <= '0;
        end else begin
            sz = m_stk.size();
            m_drive <= 1'b0;
            case (cmd)
                SC_PUS: if (sz == DEPTH) m_err <= 1'b1; else m_stk.push_back(drv);
                SC_POP: if (sz == 0) m_err <= 1'b1;
                        else begin m_val <= m_stk.pop_back(); m_drive <= 1'b1; end
                SC_TOP: if (sz == 0) m_err <= 1'b1;
                        else begin m_val <= m_stk[sz-1]; m_drive <= 1'b1; end
                SC_DUP: if (sz == 0 || sz == DEPTH) m_err <= 1'b1;
                        else m_stk.push_back(m_stk[sz-1]);
                SC_SWP: if (sz < 2) m_err <= 1'b1;
                        else begin
                            tmp          = m_stk[sz-1];
                            m_stk[sz-1]  = m_stk[sz-2];
                            m_stk[sz-2]  = tmp;
                        end
                SC_CLR: begin m_stk.delete(); m_err <= 1'b0; end
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        chk("count",  32'(count), 32'(m_stk.size()));
        chk("empty",  32'(empty), 32'(m_stk.size() == 0));
        chk("full",   32'(full),  32'(m_stk.size() == DEPTH));
        chk("err",    32'(err),   32'(m_err));
        chk("data",   32'(data),  m_drive ? 32'(m_val) : 32'(drv));
    end

    // Present a command, let it be sampled, then settle past the edge.
    task automatic step(input logic [SC_N-1:0] c, input logic [N-1:0] v);
        cmd = c;
        drv = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_bus",   32'(data),  32'(drv));
        rst_n = 1'b1;

        // Push two, pop back-to-back.
        step(SC_PUS, 16'h1111);
        step(SC_PUS, 16'h2222);
        step(SC_POP, 16'h0000);  chk("pop1", 32'(data), 32'h2222);
        step(SC_POP, 16'h0000);  chk("pop2", 32'(data), 32'h1111);
        step(SC_NOP, 16'h0000);
        chk("a_empty", 32'(empty), 32'd1);
        chk("a_err",   32'(err),   32'd0);
        chk("a_bus",   32'(data),  32'h0);

        // Fill, overflow, drain.
        step(SC_PUS, 16'h000A);
        step(SC_PUS, 16'h000B);
        step(SC_PUS, 16'h000C);
        step(SC_PUS, 16'h000D);
        chk("b_full",  32'(full),  32'd1);
        chk("b_count", 32'(count), 32'd4);
        step(SC_PUS, 16'h000E);
        chk("ovf_err",   32'(err),   32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        step(SC_POP, 16'h0000);  chk("drain_d", 32'(data), 32'h000D);
        step(SC_POP, 16'h0000);  chk("drain_c", 32'(data), 32'h000C);
        step(SC_POP, 16'h0000);  chk("drain_b", 32'(data), 32'h000B);
        step(SC_POP, 16'h0000);  chk("drain_a", 32'(data), 32'h000A);
        chk("sticky_err", 32'(err), 32'd1);
        step(SC_NOP, 16'h0000);
        step(SC_CLR, 16'h0000);

        // Underflow from empty.
        step(SC_POP, 16'h0000);
        chk("udf_err",   32'(err),   32'd1);
        chk("udf_count", 32'(count), 32'd0);
        chk("udf_bus",   32'(data),  32'h0);
        step(SC_CLR, 16'h0000);
        chk("clr_err", 32'(err), 32'd0);

        // Swap and duplicate.
        step(SC_PUS, 16'h0005);
        step(SC_PUS, 16'h0006);
        step(SC_SWP, 16'h0000);
        step(SC_POP, 16'h0000);  chk("swp_pop1", 32'(data), 32'h0005);
        step(SC_POP, 16'h0000);  chk("swp_pop2", 32'(data), 32'h0006);
        step(SC_NOP, 16'h0000);
        step(SC_PUS, 16'h0007);
        step(SC_DUP, 16'h0000);
        step(SC_POP, 16'h0000);  chk("dup_pop1", 32'(data), 32'h0007);
        step(SC_POP, 16'h0000);  chk("dup_pop2", 32'(data), 32'h0007);
        step(SC_NOP, 16'h0000);

        // TOP holds the value without popping; undefined code acts as NOP.
        step(SC_PUS, 16'h0009);
        step(SC_TOP, 16'h0000);
        chk("top1", 32'(data), 32'h0009);
        chk("top1_count", 32'(count), 32'd1);
        step(SC_TOP, 16'h0000);
        chk("top2", 32'(data), 32'h0009);
        chk("top2_count", 32'(count), 32'd1);
        step(SC_NOP, 16'h0000);
        chk("top_release", 32'(data), 32'h0);
        step(3'd7, 16'h0000);
        chk("undef_count", 32'(count), 32'd1);
        chk("undef_err",   32'(err),   32'd0);

        // SWP with one entry, DUP when full.
        step(SC_SWP, 16'h0000);
        chk("swp_udf_err",   32'(err),   32'd1);
        chk("swp_udf_count", 32'(count), 32'd1);
        step(SC_CLR, 16'h0000);
        for (int i = 0; i < 4; i++) step(SC_PUS, 16'(16'h0040 + i));
        step(SC_DUP, 16'h0000);
        chk("dup_ovf_err",   32'(err),   32'd1);
        chk("dup_ovf_count", 32'(count), 32'd4);
        step(SC_POP, 16'h0000);  chk("dup_ovf_top", 32'(data), 32'h0043);
        step(SC_NOP, 16'h0000);
        step(SC_CLR, 16'h0000);

        // Reset during a result cycle.
        step(SC_PUS, 16'h0003);
        step(SC_SWP, 16'h0000);
        step(SC_POP, 16'h0000);  chk("pre_rst", 32'(data), 32'h0003);
        #1;
        cmd = SC_PUS;
        drv = 16'h0000;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus",   32'(data),  32'h0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_err",   32'(err),   32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        drv = 16'h0077;
        @(posedge clk);
        #2;
        chk("rst_no_exec", 32'(count), 32'd0);
        cmd = SC_NOP;
        drv = 16'h0000;
        rst_n = 1'b1;
        step(SC_NOP, 16'h0000);
        step(SC_PUS, 16'h00C3);
        step(SC_POP, 16'h0000);  chk("post_rst", 32'(data), 32'h00C3);
        step(SC_NOP, 16'h0000);
        step(SC_NOP, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_stack.md
OP_STACK -- requirements
Module: op_stack

Interface
REQ-001 Parameter N, default 16: data word width in bits.
REQ-002 Parameter AW, default 6: address width; DEPTH = 2**AW entries.
REQ-003 Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 data  inout  N  shared tri-state bus: push operand in, pop/top result out; high-Z when not driving.
REQ-006 cmd  input  `SC_N  command code, sampled every rising Clock edge.
REQ-007 count  output  AW+1  number of valid entries, 0..DEPTH.
REQ-008 empty  output  1  high when count == 0.
REQ-009 full  output  1  high when count == DEPTH.
REQ-010 err  output  1  sticky overflow/underflow flag.

Function
REQ-011 The stack SHALL treat ptr as the next free slot; top of stack = ram[ptr-1]; second = ram[ptr-2].
REQ-012 SC_NOP: no state change; the bus SHALL be released (out_ena = 0) at the next edge.
REQ-013 SC_PUS when not full: write data to ram[ptr], ptr+1, release bus.
REQ-014 SC_POP when not empty: buff <= top, ptr-1, drive bus from the following cycle.
REQ-015 SC_TOP when not empty: buff <= top, ptr unchanged, drive bus from the following cycle.
REQ-016 SC_DUP when count >= 1 and not full: ram[ptr] <= top, ptr+1, release bus.
REQ-017 SC_SWP when count >= 2: exchange top and second in one cycle, ptr unchanged, release bus.
REQ-018 SC_CLR: ptr <= 0, err <= 0, release bus; RAM contents need not be cleared.
REQ-019 Result latency SHALL be exactly one cycle: value appears on data in the cycle after the POP/TOP edge and stays driven until the next edge sampling a non-POP/TOP command.
REQ-020 Back-to-back POPs SHALL drive consecutive entries on consecutive cycles without a high-Z gap.
REQ-021 Overflow (PUS or DUP when full): SHALL leave ptr and RAM unchanged, set err, release bus.
REQ-022 Underflow (POP/TOP/DUP when empty, SWP when count < 2): SHALL leave ptr and RAM unchanged, set err, release bus; buff unchanged.
REQ-023 ptr SHALL never wrap; count SHALL saturate exactly at 0 and DEPTH.
REQ-024 err SHALL remain set until SC_CLR or Reset; other commands continue to execute normally while err is set.
REQ-025 Undefined cmd codes SHALL behave as SC_NOP.
REQ-026 count, empty, full SHALL be registered or derived combinationally from ptr, updated in the cycle after the command edge.

Reset
REQ-027 Reset low SHALL immediately force ptr = 0, buff = 0, out_ena = 0 (data high-Z), err = 0; hence count = 0, empty = 1, full = 0.
REQ-028 Reset asserted mid-operation SHALL abort any pending result; no command is executed on the edge on which Reset is low.
REQ-029 RAM contents SHALL NOT be reset.

Structure
REQ-030 Command codes SC_NOP, SC_PUS, SC_POP, SC_TOP, SC_DUP, SC_SWP, SC_CLR and width SC_N (3) SHALL live in the shared STACK_INTERFACE header; existing codes keep their values, new ones take unused codes.
REQ-031 The storage array SHALL be a sub-module stack_ram (N x DEPTH, one read port at ptr-1, one at ptr-2, two write ports) so a memory macro can replace it later.
REQ-032 The command decode and pointer/flag logic SHALL stay in op_stack.

Verification (N=16, AW=2, DEPTH=4)
REQ-033 Reset; PUS 0x1111, 0x2222; POP; POP -> data = 0x2222 then 0x1111 on consecutive cycles, then empty = 1, err = 0.
REQ-034 PUS 0xA, 0xB, 0xC, 0xD -> full = 1, count = 4; PUS 0xE -> err = 1, count = 4; POP x4 -> 0xD, 0xC, 0xB, 0xA.
REQ-035 From empty: POP -> err = 1, data high-Z, count = 0; CLR -> err = 0.
REQ-036 PUS 0x5, 0x6; SWP; POP; POP -> 0x5 then 0x6; PUS 0x7; DUP; POP; POP -> 0x7, 0x7.
REQ-037 PUS 0x9; TOP; TOP -> data = 0x9 for two cycles, count stays 1; NOP -> data high-Z.
REQ-038 PUS 0x3; POP; assert Reset during the result cycle -> data high-Z immediately, count = 0, err = 0.
